// File: rtl/oam_dma_engine.sv
// OAM DMA engine: a CPU write to DMA_REG_ADDR stalls the CPU and copies one
// 256-byte page to the PPU OAMDATA register, one read/write pair per byte.
module oam_dma_engine #(
   parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
   parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        clock_en,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_r_en,
   input  logic [7:0]  cpu_w_data,
   input  logic [7:0]  mem_r_data,
   output logic [15:0] mem_addr,
   output logic        mem_r_en,
   output logic [7:0]  mem_w_data,
   output logic        cpu_stall,
   output logic [7:0]  dma_index
);

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALIGN = 2'd1,
      READ  = 2'd2,
      WRITE = 2'd3
   } state_t;

   state_t              state;
   logic [DATA_W-1:0]   page;
   logic                par;
   logic                trigger;

   assign trigger = (cpu_addr == DMA_REG_ADDR) && !cpu_r_en;

   // Transfer sequencer; everything advances only on enabled CPU cycles
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         page      <= '0;
         dma_index <= '0;
         par       <= 1'b0;
      end else if (clock_en) begin
         par <= ~par;
         case (state)
            IDLE: begin
               if (trigger) begin
                  page      <= cpu_w_data;
                  dma_index <= '0;
                  state     <= ALIGN;
               end
            end
            ALIGN: begin
               // leave only on an even cycle so READ lands on the get phase
               if (!par) state <= READ;
            end
            READ: begin
               state <= WRITE;
            end
            WRITE: begin
               if (dma_index != 8'hFF) begin
                  dma_index <= dma_index + DATA_W'(1);
                  state     <= READ;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bus mux: CPU pass-through when idle, engine-driven otherwise
   always_comb begin
      mem_addr   = cpu_addr;
      mem_r_en   = cpu_r_en;
      mem_w_data = cpu_w_data;
      case (state)
         ALIGN: begin
            mem_r_en   = 1'b1;
            mem_w_data = '0;
         end
         READ: begin
            mem_addr   = ADDR_W'({page, dma_index});
            mem_r_en   = 1'b1;
            mem_w_data = '0;
         end
         WRITE: begin
            mem_addr   = OAMDATA_ADDR;
            mem_r_en   = 1'b0;
            mem_w_data = mem_r_data;
         end
         default: ;
      endcase
   end

   assign cpu_stall = (state != IDLE);

endmodule

// File: tb/tb_oam_dma_engine.sv
// Bench for oam_dma_engine: random memory image, scoreboard of expected
// OAMDATA writes, monitor on the falling edge, driver after the rising edge.
module tb_oam_dma_engine;

   localparam logic [15:0] DMA_REG = 16'h4014;
   localparam logic [15:0] OAMDATA = 16'h2004;

   logic        clock;
   logic        reset_n;
   logic        clock_en;
   logic [15:0] cpu_addr;
   logic        cpu_r_en;
   logic [7:0]  cpu_w_data;
   logic [7:0]  mem_r_data = 8'h00;
   logic [15:0] mem_addr;
   logic        mem_r_en;
   logic [7:0]  mem_w_data;
   logic        cpu_stall;
   logic [7:0]  dma_index;

   oam_dma_engine #(.DMA_REG_ADDR(16'h4014), .OAMDATA_ADDR(16'h2004)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .clock_en   (clock_en),
      .cpu_addr   (cpu_addr),
      .cpu_r_en   (cpu_r_en),
      .cpu_w_data (cpu_w_data),
      .mem_r_data (mem_r_data),
      .mem_addr   (mem_addr),
      .mem_r_en   (mem_r_en),
      .mem_w_data (mem_w_data),
      .cpu_stall  (cpu_stall),
      .dma_index  (dma_index)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [7:0] mem [0:65535];

   // Memory model: read data appears after the enabled cycle that addressed it
   always @(posedge clock) begin
      if (clock_en && mem_r_en) mem_r_data <= mem[mem_addr];
   end

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q [$];
   int en_cnt = 0;
   int stall_cnt = 0;
   int trig_cnt = 0;
   int first_rd = -1;
   int stab_err = 0;
   int oam_writes = 0;
   logic [7:0] dma_page = 8'h00;
   logic [7:0] mon_exp;
   logic [33:0] prev_vec = '0;
   logic prev_en = 1'b0;
   logic prev_stall = 1'b0;
   logic have_prev = 1'b0;
   logic abort_all = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: counts enabled cycles, stall cycles and checks every OAMDATA write
   always @(negedge clock) begin
      if (!reset_n) begin
         en_cnt    = 0;
         have_prev = 1'b0;
      end else begin
         if (have_prev && !prev_en && prev_stall && cpu_stall &&
             ({mem_addr, mem_r_en, mem_w_data, cpu_stall, dma_index} != prev_vec))
            stab_err++;
         if (clock_en) begin
            if (cpu_stall) stall_cnt++;
            if (cpu_stall && mem_r_en && mem_addr == {dma_page, 8'h00} && first_rd < 0)
               first_rd = en_cnt - trig_cnt;
            if (!mem_r_en && mem_addr == OAMDATA) begin
               oam_writes++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL oam_unexpected: got write %0h expected none at %0t", mem_w_data, $time);
               end else begin
                  mon_exp = exp_q.pop_front();
                  check("oam_data", 32'(mem_w_data), 32'(mon_exp));
               end
            end
            en_cnt++;
         end
         prev_vec   = {mem_addr, mem_r_en, mem_w_data, cpu_stall, dma_index};
         prev_en    = clock_en;
         prev_stall = cpu_stall;
         have_prev  = 1'b1;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_idle();
      cpu_addr   = 16'($urandom) & 16'h07FF;
      cpu_r_en   = 1'b1;
      cpu_w_data = 8'($urandom);
      clock_en   = 1'b1;
   endtask

   // One DMA: align parity, trigger, run to completion (or abort by reset)
   task automatic run_dma(input logic [7:0] page, input int want_par, input int mode,
                          input int abort_at);
      int k;
      logic done;
      if (abort_all) return;
      drive_idle();
      step();
      while ((en_cnt % 2) != want_par) step();
      for (int i = 0; i < 256; i++) begin
         if (page == 8'h03) exp_q.push_back(8'(i) ^ 8'h5A);
         else exp_q.push_back(mem[{page, 8'(i)}]);
      end
      stall_cnt  = 0;
      stab_err   = 0;
      first_rd   = -1;
      trig_cnt   = en_cnt;
      dma_page   = page;
      cpu_addr   = DMA_REG;
      cpu_r_en   = 1'b0;
      cpu_w_data = page;
      clock_en   = 1'b1;
      done = 1'b0;
      k = 0;
      while (!done && k < 5000) begin
         step();
         k++;
         if (!cpu_stall) begin
            done = 1'b1;
         end else if (abort_at >= 0 && int'(dma_index) == abort_at) begin
            #2;
            reset_n = 1'b0;
            #1;
            check("reset_stall", 32'(cpu_stall), 32'(0));
            check("reset_index", 32'(dma_index), 32'(0));
            check("reset_addr", 32'(mem_addr), 32'(DMA_REG));
            check("reset_r_en", 32'(mem_r_en), 32'(0));
            check("reset_w_data", 32'(mem_w_data), 32'(page));
            exp_q.delete();
            drive_idle();
            repeat (3) step();
            reset_n = 1'b1;
            oam_writes = 0;
            repeat (30) step();
            check("abort_no_writes", 32'(oam_writes), 32'(0));
            check("abort_stall", 32'(cpu_stall), 32'(0));
            return;
         end else begin
            case (mode)
               1:       clock_en = ((k % 3) == 0);
               2:       clock_en = 1'($urandom_range(0, 1));
               default: clock_en = 1'b1;
            endcase
         end
      end
      drive_idle();
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL dma_timeout: got stall still high expected done at %0t", $time);
         abort_all = 1'b1;
         return;
      end
      step();
      check("stall_cycles", 32'(stall_cnt), (want_par == 1) ? 32'd513 : 32'd514);
      check("first_read_offset", 32'(first_rd), (want_par == 1) ? 32'd2 : 32'd3);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("stable_when_disabled", 32'(stab_err), 32'd0);
      check("final_index", 32'(dma_index), 32'hFF);
      check("no_retrigger", 32'(cpu_stall), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[16'h0300 + 16'(i)] = 8'(i) ^ 8'h5A;

      reset_n    = 1'b0;
      clock_en   = 1'b1;
      cpu_addr   = 16'h1234;
      cpu_r_en   = 1'b1;
      cpu_w_data = 8'h77;
      #1;
      check("rst_stall", 32'(cpu_stall), 32'd0);
      check("rst_index", 32'(dma_index), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'h1234);
      check("rst_w_data", 32'(mem_w_data), 32'h77);
      repeat (3) step();
      reset_n = 1'b1;

      // Pass-through of nearby registers must not start a transfer
      step();
      cpu_addr = 16'h4015; cpu_r_en = 1'b0; cpu_w_data = 8'hAA; clock_en = 1'b1;
      #1;
      check("pt_addr", 32'(mem_addr), 32'h4015);
      check("pt_r_en", 32'(mem_r_en), 32'd0);
      check("pt_w_data", 32'(mem_w_data), 32'hAA);
      step();
      check("pt_stall_4015", 32'(cpu_stall), 32'd0);
      cpu_addr = DMA_REG; cpu_r_en = 1'b1; cpu_w_data = 8'h55;
      #1;
      check("pt_rd_addr", 32'(mem_addr), 32'h4014);
      check("pt_rd_r_en", 32'(mem_r_en), 32'd1);
      step();
      check("pt_stall_4014_read", 32'(cpu_stall), 32'd0);
      drive_idle();
      repeat (2) step();
      check("pt_no_dma", 32'(cpu_stall), 32'd0);

      run_dma(8'h02, 1, 0, -1);
      run_dma(8'h02, 0, 0, -1);
      run_dma(8'h03, int'($urandom_range(0, 1)), 0, -1);
      run_dma(8'h07, int'($urandom_range(0, 1)), 1, -1);
      run_dma(8'($urandom), int'($urandom_range(0, 1)), 2, -1);
      run_dma(8'h11, 1, 0, 8'h40);
      run_dma(8'h05, int'($urandom_range(0, 1)), 0, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/oam_dma_engine.md
OAM_DMA_ENGINE -- requirements
Module: oam_dma_engine

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'h4014: CPU address whose write triggers a DMA.
REQ-002 SHALL have parameter OAMDATA_ADDR, default 16'h2004: PPU OAMDATA address that DMA writes target.
REQ-003 SHALL have port clock, input, 1: system clock; all state on posedge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port clock_en, input, 1: CPU cycle enable; state advances only when high.
REQ-006 SHALL have port cpu_addr, input, 16: CPU bus address.
REQ-007 SHALL have port cpu_r_en, input, 1: CPU read enable (1 read, 0 write).
REQ-008 SHALL have port cpu_w_data, input, 8: CPU write data.
REQ-009 SHALL have port mem_r_data, input, 8: memory read data, valid in the enabled cycle after the read address.
REQ-010 SHALL have port mem_addr, output, 16: address to memory.
REQ-011 SHALL have port mem_r_en, output, 1: read enable to memory.
REQ-012 SHALL have port mem_w_data, output, 8: write data to memory.
REQ-013 SHALL have port cpu_stall, output, 1: high while a DMA owns the bus; the CPU holds its state.
REQ-014 SHALL have port dma_index, output, 8: current byte offset within the source page.

Function
REQ-015 SHALL implement states IDLE, ALIGN, READ and WRITE in a registered state variable.
REQ-016 Output mux in IDLE SHALL be pass-through: mem_addr=cpu_addr, mem_r_en=cpu_r_en, mem_w_data=cpu_w_data (combinational).
REQ-017 Trigger SHALL fire in IDLE when clock_en=1, cpu_addr==DMA_REG_ADDR and cpu_r_en=0; the trigger write SHALL pass through to memory unchanged.
REQ-018 On trigger SHALL latch page=cpu_w_data, clear dma_index to 0 and go to ALIGN.
REQ-019 SHALL keep parity bit par: reset 0, toggled every clock_en cycle regardless of state.
REQ-020 In ALIGN: if par==0, go to READ; if par==1, stay in ALIGN one more cycle. Each ALIGN cycle SHALL drive mem_addr=cpu_addr, mem_r_en=1 and mem_w_data=0 (dummy read).
REQ-021 In READ SHALL drive mem_addr={page,dma_index}, mem_r_en=1 and mem_w_data=0, then go to WRITE.
REQ-022 In WRITE SHALL drive mem_addr=OAMDATA_ADDR, mem_r_en=0 and mem_w_data=mem_r_data.
REQ-023 In WRITE with dma_index!=8'hFF SHALL increment dma_index and go to READ; with dma_index==8'hFF it SHALL go to IDLE and hold dma_index at 8'hFF.
REQ-024 cpu_stall SHALL equal (state!=IDLE), combinational from the registered state; total stall SHALL be 513 cycles (1 ALIGN) or 514 cycles (2 ALIGN).
REQ-025 With clock_en=0: state, page, dma_index and par SHALL hold; outputs SHALL remain a function of the held state.
REQ-026 While not IDLE, writes to DMA_REG_ADDR SHALL be ignored (no retrigger).
REQ-027 dma_index SHALL wrap only by return to IDLE; it SHALL never exceed 8 bits.

Reset
REQ-028 On reset_n=0, immediately and asynchronously: state=IDLE, page=0, dma_index=0, par=0, cpu_stall=0, and the mux in pass-through.
REQ-029 Reset asserted mid-transfer SHALL abort the DMA with no further OAMDATA writes after release.
REQ-030 After reset release, the first trigger SHALL behave per REQ-017 to REQ-024.

Verification
REQ-031 Trigger write 8'h02 to 4014 at par=1 (trigger cycle toggles par to 0) -> one ALIGN; READ 0200, WRITE 2004 with data of 0200; ... READ 02FF, WRITE 2004; cpu_stall high exactly 513 enabled cycles.
REQ-032 Trigger at par=0 -> two ALIGN cycles; cpu_stall high 514 cycles; first READ address 16'h0200 one cycle later than REQ-031.
REQ-033 Preload 0300..03FF with byte=offset^8'h5A, DMA page 8'h03 -> 256 OAMDATA writes in order, with values 8'h5A, 8'h5B, ..., 8'hA5.
REQ-034 Toggle clock_en 1-of-3 during a DMA -> the same write sequence and cycle count measured in enabled cycles; outputs stable across disabled cycles.
REQ-035 Assert reset_n at dma_index=8'h40 -> cpu_stall=0 the same instant; no 2004 writes after release; a new trigger to page 8'h05 completes normally.
REQ-036 While IDLE, CPU writes 8'hAA to 16'h4015 and reads 16'h4014 -> pure pass-through, cpu_stall stays 0, no DMA.
